// File: rtl/aes_csr_bank.sv
// CSR bank fronting an AES core: key/message registers, captured result,
// CTRL start trigger and STATUS with done/err W1C flags and interrupt enable.
module aes_csr_bank #(
  parameter int KEY_WORDS = 4,
  parameter int MSG_WORDS = 4,
  parameter int ADDR_W    = 4
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   cs,
  input  logic                   r,
  input  logic                   w,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [3:0]             byte_en,
  input  logic [31:0]            Din,
  output logic [31:0]            Dout,
  output logic [KEY_WORDS*32-1:0] key_o,
  output logic [MSG_WORDS*32-1:0] msg_o,
  output logic                   start_o,
  input  logic                   core_done_i,
  input  logic [MSG_WORDS*32-1:0] result_i,
  output logic                   busy_o,
  output logic                   irq_o
);

  localparam int CTRL_ADDR   = KEY_WORDS + 2*MSG_WORDS;
  localparam int STATUS_ADDR = CTRL_ADDR + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nx;
  logic [31:0] key_q [KEY_WORDS];
  logic [31:0] msg_q [MSG_WORDS];
  logic [31:0] res_q [MSG_WORDS];
  logic        done, done_nx;
  logic        err, err_nx;
  logic        irq_en, irq_en_nx;
  logic        wr, rd;
  logic        hit_ctrl, hit_status, hit_data;
  logic        start_req, run_wr_err;
  logic [31:0] be_mask;
  logic [31:0] rd_data;

  assign wr         = cs & w;
  assign rd         = cs & r & ~w;
  assign hit_ctrl   = wr && (addr == ADDR_W'(CTRL_ADDR));
  assign hit_status = wr && (addr == ADDR_W'(STATUS_ADDR));
  assign hit_data   = wr && (addr < ADDR_W'(KEY_WORDS + MSG_WORDS));
  assign start_req  = hit_ctrl && byte_en[0] && Din[0] && (state != RUN);
  assign run_wr_err = (state == RUN) && (hit_ctrl || hit_data);
  assign be_mask    = {{8{byte_en[3]}}, {8{byte_en[2]}}, {8{byte_en[1]}}, {8{byte_en[0]}}};
  assign busy_o     = (state == RUN);

  genvar g;
  generate
    for (g = 0; g < KEY_WORDS; g++) begin : g_key
      assign key_o[g*32 +: 32] = key_q[g];
    end
    for (g = 0; g < MSG_WORDS; g++) begin : g_msg
      assign msg_o[g*32 +: 32] = msg_q[g];
    end
  endgenerate

  // Capture is evaluated last in RUN so it wins over a same-cycle done clear.
  always_comb begin
    state_nx  = state;
    done_nx   = done;
    err_nx    = err;
    irq_en_nx = irq_en;
    if (hit_status && byte_en[0]) begin
      if (Din[0]) done_nx = 1'b0;
      if (Din[2]) err_nx  = 1'b0;
      irq_en_nx = Din[3];
    end
    if (run_wr_err) err_nx = 1'b1;
    case (state)
      IDLE: begin
        if (start_req) begin
          state_nx = RUN;
          done_nx  = 1'b0;
        end
      end
      RUN: begin
        if (core_done_i) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end
      end
      DONE: begin
        if (start_req) begin
          state_nx = RUN;
          done_nx  = 1'b0;
        end else if (!done_nx) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < KEY_WORDS; i++)
      if (addr == ADDR_W'(i)) rd_data = key_q[i];
    for (int i = 0; i < MSG_WORDS; i++) begin
      if (addr == ADDR_W'(KEY_WORDS + i)) rd_data = msg_q[i];
      if (addr == ADDR_W'(KEY_WORDS + MSG_WORDS + i)) rd_data = res_q[i];
    end
    if (addr == ADDR_W'(STATUS_ADDR))
      rd_data = {28'd0, irq_en, err, busy_o, done};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      err     <= 1'b0;
      irq_en  <= 1'b0;
      start_o <= 1'b0;
      irq_o   <= 1'b0;
      Dout    <= '0;
      for (int i = 0; i < KEY_WORDS; i++) key_q[i] <= '0;
      for (int i = 0; i < MSG_WORDS; i++) begin
        msg_q[i] <= '0;
        res_q[i] <= '0;
      end
    end else begin
      state   <= state_nx;
      done    <= done_nx;
      err     <= err_nx;
      irq_en  <= irq_en_nx;
      start_o <= start_req;
      irq_o   <= done_nx & irq_en_nx;
      if (rd) Dout <= rd_data;
      // Key and message registers are frozen while the core is consuming them.
      for (int i = 0; i < KEY_WORDS; i++)
        if (wr && (state != RUN) && (addr == ADDR_W'(i)))
          key_q[i] <= (key_q[i] & ~be_mask) | (Din & be_mask);
      for (int i = 0; i < MSG_WORDS; i++) begin
        if (wr && (state != RUN) && (addr == ADDR_W'(KEY_WORDS + i)))
          msg_q[i] <= (msg_q[i] & ~be_mask) | (Din & be_mask);
        if ((state == RUN) && core_done_i)
          res_q[i] <= result_i[i*32 +: 32];
      end
    end
  end

endmodule
